// File: rtl/stage_4_pkg.sv
// stage_4_pkg: opcodes, load/store width codes, FSM states and access legality check for the memory stage
package stage_4_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // legal width code for the direction and natural alignment of the address
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] a, input logic st);
        return f3 == F3_B || (f3 == F3_H && !a[0]) || (f3 == F3_W && a == 2'b00) ||
               (!st && (f3 == F3_BU || (f3 == F3_HU && !a[0])));
    endfunction

endpackage

// File: rtl/stage_4_load_align.sv
// stage_4_load_align: selects the addressed byte/half of a read word and sign/zero extends it
module stage_4_load_align
    import stage_4_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  func_3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];

    // extension by width code; word loads pass through verbatim
    always_comb begin
        data = func_3 == F3_B  ? {{24{b[7]}}, b} :
               func_3 == F3_BU ? {24'h0, b} :
               func_3 == F3_H  ? {{16{h[15]}}, h} :
               func_3 == F3_HU ? {16'h0, h} : rdata;
    end

endmodule

// File: rtl/stage_4.sv
// stage_4: RV32I memory-access stage; drives data memory over req/ack and forwards results to writeback
module stage_4
    import stage_4_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_rs_2,
    input  logic [4:0]  i_rd_num,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_func_3,
    input  logic        i_op_type,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        o_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_rd_num,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    lane;
    logic [2:0]    f3_q;
    logic [31:0]   load_val;
    logic          is_st, mem_ok, idle_v, take_alu, take_mem, take_bad, done;

    assign is_st    = i_opcode == OPC_STORE;
    assign mem_ok   = (i_opcode == OPC_LOAD || is_st) && access_ok(i_func_3, i_alu_out[1:0], is_st);
    assign idle_v   = state == S_IDLE && i_valid;
    assign take_alu = idle_v && !i_op_type;
    assign take_mem = idle_v && i_op_type && mem_ok;
    assign take_bad = idle_v && i_op_type && !mem_ok;
    assign done     = state == S_ACCESS && (mem_ack || wait_cnt == CW'(TIMEOUT - 1));
    assign stall    = state == S_ACCESS;
    assign mem_req  = state == S_ACCESS;

    stage_4_load_align u_align (
        .rdata  (mem_rdata),
        .addr   (lane),
        .func_3 (f3_q),
        .data   (load_val)
    );

    // next state: accept a legal memory op, finish on ack or timeout, then one response cycle
    always_comb begin
        state_nx = take_mem ? S_ACCESS : done ? S_RESP : state == S_RESP ? S_IDLE : state;
    end

    // state register; reset abandons any outstanding access, dropping mem_req at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // request latches, wait counter and writeback bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt     <= '0;
            lane         <= '0;
            f3_q         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            o_valid      <= 1'b0;
            o_wb_en      <= 1'b0;
            o_rd_num     <= '0;
            o_wb_data    <= '0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_valid      <= take_alu || take_bad || done;
            o_misaligned <= take_bad;
            o_bus_err    <= done && !mem_ack;
            o_wb_en      <= take_alu ? i_rd_num != 5'd0 : done && mem_ack && !mem_we && o_rd_num != 5'd0;
            wait_cnt     <= state == S_ACCESS ? wait_cnt + 1'b1 : '0;
            if (idle_v) o_rd_num <= i_rd_num;
            if (take_alu || take_bad) o_wb_data <= i_alu_out;
            if (done) o_wb_data <= mem_ack && !mem_we ? load_val : '0;
            if (take_mem) begin
                mem_we    <= is_st;
                mem_addr  <= {i_alu_out[31:2], 2'b00};
                lane      <= i_alu_out[1:0];
                f3_q      <= i_func_3;
                mem_wstrb <= !is_st ? 4'h0 : i_func_3[1] ? 4'hF :
                             i_func_3[0] ? 4'b0011 << i_alu_out[1:0] : 4'b0001 << i_alu_out[1:0];
                mem_wdata <= !is_st ? 32'h0 : i_func_3[1] ? i_rs_2 :
                             i_func_3[0] ? {2{i_rs_2[15:0]}} : {4{i_rs_2[7:0]}};
            end
        end
    end

endmodule
